synth_ctrl_initiator: RTL and testbench

SYNTH_CTRL_INITIATOR -- requirements
Module: synth_ctrl_initiator

---
 rtl/synth_ctrl_initiator.sv | 134 +++++++++++++
 tb/tb_synth_ctrl_initiator.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/synth_ctrl_initiator.sv
// synth_ctrl_initiator: staged synth control registers, committed to the synth
// outputs atomically through a four-phase req/ack handshake with the CDC responder.
module synth_ctrl_initiator #(
   parameter int N_VOICES    = 4,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic                    rd_en,
   input  logic [7:0]              addr,
   input  logic [31:0]             wdata,
   output logic [31:0]             rdata,
   output logic [24*N_VOICES-1:0]  synth_carrier_fcws,
   output logic [23:0]             synth_mod_fcw,
   output logic [4:0]              synth_mod_shift,
   output logic [N_VOICES-1:0]     synth_note_en,
   output logic [4:0]              synth_shift,
   output logic                    cpu_req,
   input  logic                    cpu_ack
);
   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_REL} state_t;
   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   state_t                  state;
   logic [24*N_VOICES-1:0]  fcw_stg;
   logic [23:0]             mod_fcw_stg;
   logic [4:0]              mod_shift_stg;
   logic [4:0]              shift_stg;
   logic [N_VOICES-1:0]     note_en_stg;
   logic                    pending;
   logic                    timeout;
   logic                    busy;
   logic [15:0]             commit_count;
   logic [CW-1:0]           cnt;
   logic [31:0]             rd_mux;
   logic                    commit_wr;
   logic                    phase_expired;

   assign busy          = state != IDLE;
   assign commit_wr     = wr_en && addr == 8'h0C;
   assign phase_expired = cnt == CW'(ACK_TIMEOUT - 1);

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_VOICES; i++)
         if (addr == 8'(i)) rd_mux = {8'h0, fcw_stg[24*i +: 24]};
      rd_mux = addr == 8'h08 ? 32'(mod_fcw_stg)
             : addr == 8'h09 ? 32'(mod_shift_stg)
             : addr == 8'h0A ? 32'(note_en_stg)
             : addr == 8'h0B ? 32'(shift_stg)
             : addr == 8'h0D ? {13'h0, busy, pending, timeout, commit_count}
             : rd_mux;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fcw_stg       <= '0;
         mod_fcw_stg   <= '0;
         mod_shift_stg <= '0;
         shift_stg     <= '0;
         note_en_stg   <= '0;
         rdata         <= '0;
      end else begin
         if (rd_en) rdata <= rd_mux;
         if (wr_en) begin
            for (int i = 0; i < N_VOICES; i++)
               if (addr == 8'(i)) fcw_stg[24*i +: 24] <= wdata[23:0];
            if (addr == 8'h08) mod_fcw_stg <= wdata[23:0];
            if (addr == 8'h09) mod_shift_stg <= wdata[4:0];
            if (addr == 8'h0A) note_en_stg <= wdata[N_VOICES-1:0];
            if (addr == 8'h0B) shift_stg <= wdata[4:0];
         end
      end
   end

   // Timeout set by the FSM is written after the clear, so a set wins a same-edge clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         cpu_req            <= 1'b0;
         synth_carrier_fcws <= '0;
         synth_mod_fcw      <= '0;
         synth_mod_shift    <= '0;
         synth_note_en      <= '0;
         synth_shift        <= '0;
         pending            <= 1'b0;
         timeout            <= 1'b0;
         commit_count       <= '0;
         cnt                <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         if (wr_en && addr == 8'h0D && wdata[0]) timeout <= 1'b0;
         if (commit_wr && busy) pending <= 1'b1;
         case (state)
            IDLE:
               if (commit_wr || pending) begin
                  synth_carrier_fcws <= fcw_stg;
                  synth_mod_fcw      <= mod_fcw_stg;
                  synth_mod_shift    <= mod_shift_stg;
                  synth_note_en      <= note_en_stg;
                  synth_shift        <= shift_stg;
                  cpu_req            <= 1'b1;
                  pending            <= 1'b0;
                  state              <= WAIT_ACK;
                  cnt                <= '0;
               end
            WAIT_ACK:
               if (cpu_ack) begin
                  cpu_req <= 1'b0;
                  state   <= WAIT_REL;
                  cnt     <= '0;
               end else if (phase_expired) begin
                  timeout <= 1'b1;
                  cpu_req <= 1'b0;
                  state   <= IDLE;
                  cnt     <= '0;
               end
            WAIT_REL:
               if (!cpu_ack) begin
                  commit_count <= commit_count + 16'd1;
                  state        <= IDLE;
                  cnt          <= '0;
               end else if (phase_expired) begin
                  timeout <= 1'b1;
                  cpu_req <= 1'b0;
                  state   <= IDLE;
                  cnt     <= '0;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_synth_ctrl_initiator.sv
// tb_synth_ctrl_initiator: directed and randomized commit/handshake scenarios checked
// against a transaction-level model of the staging registers and committed snapshot.
module tb_synth_ctrl_initiator;
   localparam int NV = 4;
   localparam int TO = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            wr_en = 1'b0;
   logic            rd_en = 1'b0;
   logic [7:0]      addr = '0;
   logic [31:0]     wdata = '0;
   logic [31:0]     rdata;
   logic [24*NV-1:0] synth_carrier_fcws;
   logic [23:0]     synth_mod_fcw;
   logic [4:0]      synth_mod_shift;
   logic [NV-1:0]   synth_note_en;
   logic [4:0]      synth_shift;
   logic            cpu_req;
   logic            cpu_ack = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [23:0] m_fcw [4];
   logic [23:0] m_mod_fcw;
   logic [4:0]  m_mod_shift;
   logic [3:0]  m_note;
   logic [4:0]  m_shift;
   logic [23:0] s_fcw [4];
   logic [23:0] s_mod_fcw;
   logic [4:0]  s_mod_shift;
   logic [3:0]  s_note;
   logic [4:0]  s_shift;
   logic        m_busy, m_pend, m_to;
   logic [15:0] m_cnt;

   synth_ctrl_initiator #(.N_VOICES(NV), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
      .rdata(rdata), .synth_carrier_fcws(synth_carrier_fcws), .synth_mod_fcw(synth_mod_fcw),
      .synth_mod_shift(synth_mod_shift), .synth_note_en(synth_note_en),
      .synth_shift(synth_shift), .cpu_req(cpu_req), .cpu_ack(cpu_ack)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset;
      for (int i = 0; i < 4; i++) begin
         m_fcw[i] = '0;
         s_fcw[i] = '0;
      end
      m_mod_fcw = '0; m_mod_shift = '0; m_note = '0; m_shift = '0;
      s_mod_fcw = '0; s_mod_shift = '0; s_note = '0; s_shift = '0;
      m_busy = 1'b0; m_pend = 1'b0; m_to = 1'b0; m_cnt = '0;
   endtask

   task automatic snap;
      s_fcw = m_fcw;
      s_mod_fcw = m_mod_fcw;
      s_mod_shift = m_mod_shift;
      s_note = m_note;
      s_shift = m_shift;
   endtask

   function automatic logic [127:0] pack_fcw();
      logic [127:0] r = '0;
      for (int i = 0; i < 4; i++) r[24*i +: 24] = s_fcw[i];
      return r;
   endfunction

   function automatic logic [31:0] exp_reg(input logic [7:0] a);
      if (a < 8'd4) return {8'h0, m_fcw[a[1:0]]};
      case (a)
         8'h08: return {8'h0, m_mod_fcw};
         8'h09: return {27'h0, m_mod_shift};
         8'h0A: return {28'h0, m_note};
         8'h0B: return {27'h0, m_shift};
         8'h0D: return {13'h0, m_busy, m_pend, m_to, m_cnt};
         default: return 32'h0;
      endcase
   endfunction

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      if (a < 8'd4) m_fcw[a[1:0]] = d[23:0];
      if (a == 8'h08) m_mod_fcw = d[23:0];
      if (a == 8'h09) m_mod_shift = d[4:0];
      if (a == 8'h0A) m_note = d[3:0];
      if (a == 8'h0B) m_shift = d[4:0];
      if (a == 8'h0D && d[0]) m_to = 1'b0;
      if (a == 8'h0C) begin
         if (m_busy) m_pend = 1'b1;
         else begin
            snap();
            m_busy = 1'b1;
         end
      end
      wr_en = 1'b1; addr = a; wdata = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd_chk(input logic [7:0] a, input string tag);
      logic [31:0] e = exp_reg(a);
      rd_en = 1'b1; addr = a;
      tick();
      rd_en = 1'b0;
      chk(tag, 128'(rdata), 128'(e));
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, ".fcws"}, 128'(synth_carrier_fcws), pack_fcw());
      chk({tag, ".mod_fcw"}, 128'(synth_mod_fcw), 128'(s_mod_fcw));
      chk({tag, ".mod_shift"}, 128'(synth_mod_shift), 128'(s_mod_shift));
      chk({tag, ".note_en"}, 128'(synth_note_en), 128'(s_note));
      chk({tag, ".shift"}, 128'(synth_shift), 128'(s_shift));
   endtask

   task automatic finish_hs(input string tag);
      cpu_ack = 1'b1;
      tick();
      chk({tag, ".req_drop"}, 128'(cpu_req), 128'(0));
      cpu_ack = 1'b0;
      tick();
      m_cnt++;
      m_busy = 1'b0;
      chk({tag, ".req_idle"}, 128'(cpu_req), 128'(0));
   endtask

   initial begin
      logic [7:0] a;
      model_reset();
      repeat (2) tick();
      chk("rst.req", 128'(cpu_req), 128'(0));
      chk("rst.rdata", 128'(rdata), 128'(0));
      chk_outs("rst");
      rst = 1'b0;
      rd_chk(8'h0D, "rst.status");

      // timeout while waiting for ack, then clear
      wr(8'h00, 32'h777);
      wr(8'h0C, 32'h0);
      chk("to.req_up", 128'(cpu_req), 128'(1));
      repeat (TO - 1) tick();
      chk("to.req_hold", 128'(cpu_req), 128'(1));
      tick();
      m_to = 1'b1; m_busy = 1'b0;
      chk("to.req_forced", 128'(cpu_req), 128'(0));
      rd_chk(8'h0D, "to.status");
      chk("to.status_lit", 128'(rdata), 128'(32'h0001_0000));
      wr(8'h0D, 32'h1);
      rd_chk(8'h0D, "to.status_clr");

      // basic commit handshake
      wr(8'h00, 32'h123456);
      wr(8'h0A, 32'h1);
      wr(8'h0C, 32'hDEAD);
      chk("basic.req", 128'(cpu_req), 128'(1));
      chk("basic.fcw0", 128'(synth_carrier_fcws[23:0]), 128'(24'h123456));
      chk_outs("basic");
      finish_hs("basic");
      rd_chk(8'h0D, "basic.status");

      // coalesced commits during WAIT_ACK
      wr(8'h0C, 32'h0);
      wr(8'h01, 32'hA);
      wr(8'h0C, 32'h0);
      wr(8'h01, 32'hB);
      wr(8'h0C, 32'h0);
      rd_chk(8'h0D, "coal.status_pend");
      finish_hs("coal1");
      snap(); m_pend = 1'b0; m_busy = 1'b1;
      tick();
      chk("coal.req2", 128'(cpu_req), 128'(1));
      chk("coal.fcw1", 128'(synth_carrier_fcws[47:24]), 128'(24'hB));
      chk_outs("coal2");
      finish_hs("coal2");
      rd_chk(8'h0D, "coal.status_cnt");

      // staging change without commit keeps old snapshot
      wr(8'h0C, 32'h0);
      wr(8'h02, 32'hABCDEF);
      wr(8'h08, 32'h55AA55);
      chk_outs("hold");
      rd_chk(8'h0D, "hold.status");
      finish_hs("hold");

      // commit on the WAIT_REL->IDLE edge
      wr(8'h0C, 32'h0);
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      wr(8'h0C, 32'h0);
      m_cnt++; m_busy = 1'b0;
      chk("edge.req_low", 128'(cpu_req), 128'(0));
      rd_chk(8'h0D, "edge.status");
      snap(); m_pend = 1'b0; m_busy = 1'b1;
      chk("edge.req_up", 128'(cpu_req), 128'(1));
      chk_outs("edge");
      finish_hs("edge");

      // randomized staging traffic and handshakes
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(1, 6)) begin
            a = 8'($urandom_range(0, 15));
            if (a == 8'h0C || a == 8'h0D) a = 8'h40;
            wr(a, $urandom);
         end
         rd_chk(8'($urandom_range(0, 15)), "rnd.read");
         wr(8'h0C, $urandom);
         chk("rnd.req", 128'(cpu_req), 128'(1));
         chk_outs("rnd");
         repeat ($urandom_range(0, 5)) tick();
         finish_hs("rnd");
         rd_chk(8'h0D, "rnd.status");
      end

      // reset in WAIT_REL with a concurrent write, then a stale ack
      wr(8'h0C, 32'h0);
      cpu_ack = 1'b1;
      tick();
      rst = 1'b1; wr_en = 1'b1; addr = 8'h00; wdata = 32'hFFFFFF;
      tick();
      rst = 1'b0; wr_en = 1'b0;
      model_reset();
      chk("rst2.req", 128'(cpu_req), 128'(0));
      chk_outs("rst2");
      rd_chk(8'h0D, "rst2.status");
      repeat (3) tick();
      chk("stale.req", 128'(cpu_req), 128'(0));
      rd_chk(8'h0D, "stale.status");
      rd_chk(8'h00, "rst2.fcw0");
      cpu_ack = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
